// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multicycle FSM that sequences fetch/decode/execute/writeback and drives datapath controls
module multicycle_ctrl #(
  parameter bit MEM_HANDSHAKE = 1'b1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_en,
  output logic       iord,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_control,
  output logic [1:0] pc_src,
  output logic       illegal
);
  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMREAD  = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWRITE = 4'd5;
  localparam logic [3:0] S_EXECUTE  = 4'd6;
  localparam logic [3:0] S_ALUWB    = 4'd7;
  localparam logic [3:0] S_BRANCH   = 4'd8;
  localparam logic [3:0] S_ADDIEX   = 4'd9;
  localparam logic [3:0] S_ADDIWB   = 4'd10;
  localparam logic [3:0] S_JUMP     = 4'd11;
  localparam logic [3:0] S_TRAP     = 4'd12;

  logic [3:0] state_q, state_d;
  logic       rdy, r_ok, is_mem;
  logic       pc_write, branch, ir_w, mem_w, reg_w, ill;

  assign rdy    = MEM_HANDSHAKE ? mem_ready : 1'b1;
  assign r_ok   = (op == 6'b000000) && (funct == 6'b100000 || funct == 6'b100010 ||
                                        funct == 6'b100100 || funct == 6'b100101);
  assign is_mem = (op == 6'b100011) || (op == 6'b101011);

  // state register; reset abandons any instruction in flight and restarts at FETCH
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_FETCH;
    else          state_q <= state_d;
  end

  // next-state logic; unused codes fall through to FETCH
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:    state_d = rdy ? S_DECODE : S_FETCH;
      S_DECODE:   state_d = is_mem ? S_MEMADR : r_ok ? S_EXECUTE : (op == 6'b000100) ? S_BRANCH :
                            (op == 6'b001000) ? S_ADDIEX : (op == 6'b000010) ? S_JUMP : S_TRAP;
      S_MEMADR:   state_d = (op == 6'b100011) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  state_d = rdy ? S_MEMWB : S_MEMREAD;
      S_MEMWRITE: state_d = rdy ? S_FETCH : S_MEMWRITE;
      S_EXECUTE:  state_d = S_ALUWB;
      S_ADDIEX:   state_d = S_ADDIWB;
      default:    state_d = S_FETCH;
    endcase
  end

  // output decode; write enables are masked while reset is held
  always_comb begin
    pc_write    = 1'b0;
    branch      = 1'b0;
    ir_w        = 1'b0;
    mem_w       = 1'b0;
    reg_w       = 1'b0;
    ill         = 1'b0;
    iord        = 1'b0;
    reg_dst     = 1'b0;
    mem_to_reg  = 1'b0;
    alu_src_a   = 1'b0;
    alu_src_b   = 2'b00;
    alu_control = 3'b010;
    pc_src      = 2'b00;
    case (state_q)
      S_FETCH: begin
        alu_src_b = 2'b01;
        ir_w      = rdy;
        pc_write  = rdy;
      end
      S_DECODE:   alu_src_b = 2'b11;
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_MEMREAD:  iord = 1'b1;
      S_MEMWB: begin
        mem_to_reg = 1'b1;
        reg_w      = 1'b1;
      end
      S_MEMWRITE: begin
        iord  = 1'b1;
        mem_w = 1'b1;
      end
      S_EXECUTE: begin
        alu_src_a   = 1'b1;
        alu_control = (funct == 6'b100010) ? 3'b110 : (funct == 6'b100100) ? 3'b000 :
                      (funct == 6'b100101) ? 3'b001 : 3'b010;
      end
      S_ALUWB: begin
        reg_dst = 1'b1;
        reg_w   = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a   = 1'b1;
        alu_control = 3'b110;
        branch      = 1'b1;
        pc_src      = 2'b01;
      end
      S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_ADDIWB:   reg_w = 1'b1;
      S_JUMP: begin
        pc_src   = 2'b10;
        pc_write = 1'b1;
      end
      S_TRAP:     ill = 1'b1;
      default:    alu_src_b = 2'b01;
    endcase
  end

  assign pc_en     = reset_n & (pc_write | (branch & zero));
  assign ir_write  = reset_n & ir_w;
  assign mem_write = reset_n & mem_w;
  assign reg_write = reset_n & reg_w;
  assign illegal   = reset_n & ill;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: instruction-level model of the control outputs compared every cycle
module tb_multicycle_ctrl;
  logic       clk = 1'b0;
  logic       reset_n;
  logic [5:0] op, funct;
  logic       zero, mem_ready;
  logic       pc_en, iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a, illegal;
  logic [1:0] alu_src_b, pc_src;
  logic [2:0] alu_control;

  typedef struct packed {
    logic       pc_en, iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, src_a;
    logic [1:0] src_b;
    logic [2:0] alu;
    logic [1:0] pc_src;
    logic       illegal;
  } outs_t;

  outs_t exp_v, act;
  logic  chk = 1'b0;
  string tname = "";
  int checks = 0, errors = 0;
  int ncyc, rw_cnt, mw_cnt, il_cnt, io_cnt, pe_cnt;

  multicycle_ctrl dut (
    .clk(clk), .reset_n(reset_n), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .pc_en(pc_en), .iord(iord), .mem_write(mem_write), .ir_write(ir_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_control(alu_control), .pc_src(pc_src), .illegal(illegal)
  );

  always #5 clk = ~clk;

  // single compare point, mid-cycle, plus pulse tallies of the DUT outputs
  always @(negedge clk) begin
    if (chk) begin
      act = {pc_en, iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a,
             alu_src_b, alu_control, pc_src, illegal};
      checks++;
      if (act !== exp_v) begin
        errors++;
        $display("FAIL %s cycle %0d: got %h want %h", tname, ncyc, act, exp_v);
      end
      ncyc++;
      rw_cnt += int'(reg_write);
      mw_cnt += int'(mem_write);
      il_cnt += int'(illegal);
      io_cnt += int'(iord);
      pe_cnt += int'(pc_en);
    end
  end

  function automatic outs_t base();
    outs_t b;
    b = '0;
    b.alu = 3'b010;
    return b;
  endfunction

  function automatic outs_t ef(input logic mr);
    outs_t b;
    b = base();
    b.src_b = 2'b01;
    b.pc_en = mr;
    b.ir_write = mr;
    return b;
  endfunction

  function automatic outs_t ed();
    outs_t b;
    b = base();
    b.src_b = 2'b11;
    return b;
  endfunction

  task automatic cyc(input outs_t e, input logic mr);
    mem_ready = mr;
    exp_v = e;
    chk = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic clr(input string n);
    tname = n;
    ncyc = 0; rw_cnt = 0; mw_cnt = 0; il_cnt = 0; io_cnt = 0; pe_cnt = 0;
  endtask

  task automatic lit(input string n, input int a, input int e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", n, a, e);
    end
  endtask

  // expected cycle-by-cycle behaviour of one instruction, derived from its class
  task automatic run(input logic [5:0] o, input logic [5:0] f, input logic z, input int fstall, input int mstall);
    outs_t e;
    op = o; funct = f; zero = z;
    repeat (fstall) cyc(ef(1'b0), 1'b0);
    cyc(ef(1'b1), 1'b1);
    cyc(ed(), 1'b1);
    e = base();
    if (o == 6'h23 || o == 6'h2b) begin
      e.src_a = 1'b1; e.src_b = 2'b10;
      cyc(e, 1'b1);
      e = base(); e.iord = 1'b1; e.mem_write = (o == 6'h2b);
      repeat (mstall) cyc(e, 1'b0);
      cyc(e, 1'b1);
      if (o == 6'h23) begin
        e = base(); e.mem_to_reg = 1'b1; e.reg_write = 1'b1;
        cyc(e, 1'b1);
      end
    end else if (o == 6'h00 && (f == 6'h20 || f == 6'h22 || f == 6'h24 || f == 6'h25)) begin
      e.src_a = 1'b1;
      e.alu = (f == 6'h22) ? 3'b110 : (f == 6'h24) ? 3'b000 : (f == 6'h25) ? 3'b001 : 3'b010;
      cyc(e, 1'b1);
      e = base(); e.reg_dst = 1'b1; e.reg_write = 1'b1;
      cyc(e, 1'b1);
    end else if (o == 6'h04) begin
      e.src_a = 1'b1; e.alu = 3'b110; e.pc_src = 2'b01; e.pc_en = z;
      cyc(e, 1'b1);
    end else if (o == 6'h08) begin
      e.src_a = 1'b1; e.src_b = 2'b10;
      cyc(e, 1'b1);
      e = base(); e.reg_write = 1'b1;
      cyc(e, 1'b1);
    end else if (o == 6'h02) begin
      e.pc_src = 2'b10; e.pc_en = 1'b1;
      cyc(e, 1'b1);
    end else begin
      e.illegal = 1'b1;
      cyc(e, 1'b1);
    end
  endtask

  initial begin
    outs_t r;
    reset_n = 1'b0; op = '0; funct = '0; zero = 1'b0; mem_ready = 1'b0;
    clr("reset");
    r = ef(1'b0);
    repeat (2) @(posedge clk);
    #1;
    cyc(r, 1'b1);
    reset_n = 1'b1;
    clr("add");
    run(6'h00, 6'h20, 1'b0, 0, 0);
    lit("add_len", ncyc, 4);

    clr("reset_mid_exec");
    op = 6'h00; funct = 6'h20;
    cyc(ef(1'b1), 1'b1);
    cyc(ed(), 1'b1);
    reset_n = 1'b0;
    cyc(r, 1'b1);
    cyc(r, 1'b1);
    reset_n = 1'b1;
    lit("reset_no_regwrite", rw_cnt, 0);
    clr("after_reset");
    run(6'h00, 6'h20, 1'b0, 1, 0);
    lit("after_reset_len", ncyc, 5);

    clr("sub");
    run(6'h00, 6'h22, 1'b0, 0, 0);
    lit("sub_len", ncyc, 4);
    lit("sub_regwrite", rw_cnt, 1);
    clr("and");
    run(6'h00, 6'h24, 1'b1, 0, 0);
    clr("or");
    run(6'h00, 6'h25, 1'b0, 0, 0);

    clr("lw_stall2");
    run(6'h23, 6'h11, 1'b0, 0, 2);
    lit("lw_len", ncyc, 7);
    lit("lw_iord", io_cnt, 3);
    lit("lw_regwrite", rw_cnt, 1);
    clr("lw_fstall");
    run(6'h23, 6'h00, 1'b0, 1, 0);
    lit("lw_fstall_len", ncyc, 6);

    clr("beq_taken");
    run(6'h04, 6'h00, 1'b1, 0, 0);
    lit("beq_taken_len", ncyc, 3);
    lit("beq_taken_pcen", pe_cnt, 2);
    clr("beq_not");
    run(6'h04, 6'h00, 1'b0, 0, 0);
    lit("beq_not_pcen", pe_cnt, 1);

    clr("sw_stall1");
    run(6'h2b, 6'h00, 1'b0, 0, 1);
    lit("sw_len", ncyc, 5);
    lit("sw_memwrite", mw_cnt, 2);
    lit("sw_regwrite", rw_cnt, 0);

    clr("addi");
    run(6'h08, 6'h3f, 1'b0, 0, 0);
    lit("addi_len", ncyc, 4);
    clr("jump");
    run(6'h02, 6'h00, 1'b0, 0, 0);
    lit("jump_len", ncyc, 3);
    lit("jump_pcen", pe_cnt, 2);

    clr("trap_op");
    run(6'h3f, 6'h20, 1'b0, 0, 0);
    lit("trap_op_len", ncyc, 3);
    lit("trap_op_illegal", il_cnt, 1);
    lit("trap_op_writes", rw_cnt + mw_cnt, 0);
    clr("trap_slt");
    run(6'h00, 6'h2a, 1'b0, 0, 0);
    lit("trap_slt_illegal", il_cnt, 1);
    lit("trap_slt_writes", rw_cnt + mw_cnt, 0);
    clr("add_after_trap");
    run(6'h00, 6'h20, 1'b0, 0, 0);

    chk = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
